// File: rtl/reg_writeback_queue.sv
// Write-back queue in front of the register file's single write port.
// Buffers up to DEPTH writes, drains one per cycle, and forwards queued values to the read path.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_sel,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_sel,
  output logic [DATA_W-1:0]        rf_data,
  input  logic [ADDR_W-1:0]        look_sel1,
  input  logic [ADDR_W-1:0]        look_sel2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DATA_W-1:0]        fwd1,
  output logic [DATA_W-1:0]        fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [AW:0]       cnt;
  logic [ADDR_W-1:0] sel_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

  // Writes to register 0 complete the handshake but are dropped here.
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready && (in_sel != '0);
  assign pop      = !rst && drain_en && !empty;

  assign rf_we   = pop;
  assign rf_sel  = pop ? sel_mem[head]  : '0;
  assign rf_data = pop ? data_mem[head] : '0;
  assign count   = rst ? '0 : cnt;

  // Control state: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; validity is implied by head/cnt, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[tail]  <= in_sel;
      data_mem[tail] <= in_data;
    end
  end

  // Forwarding: walk oldest to youngest so the last match is the youngest.
  always_comb begin
    logic [AW-1:0] idx;
    idx  = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (!rst && ((AW+1)'(k) < cnt)) begin
        if ((look_sel1 != '0) && (sel_mem[idx] == look_sel1)) begin
          hit1 = 1'b1;
          fwd1 = data_mem[idx];
        end
        if ((look_sel2 != '0) && (sel_mem[idx] == look_sel2)) begin
          hit2 = 1'b1;
          fwd2 = data_mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with a queue-based scoreboard of pending writes.
module tb_reg_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_sel;
  logic [DATA_W-1:0] in_data;
  logic              drain_en;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_sel;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] look_sel1;
  logic [ADDR_W-1:0] look_sel2;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+DATA_W-1:0] q[$];

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .drain_en(drain_en),
    .rf_we(rf_we), .rf_sel(rf_sel), .rf_data(rf_data),
    .look_sel1(look_sel1), .look_sel2(look_sel2),
    .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest queued value for a select; bit DATA_W is the hit flag.
  function automatic logic [DATA_W:0] model_fwd(input logic [ADDR_W-1:0] s);
    logic [DATA_W:0] r;
    r = '0;
    if (s != '0)
      foreach (q[i])
        if (q[i][ADDR_W+DATA_W-1:DATA_W] == s) r = {1'b1, q[i][DATA_W-1:0]};
    return r;
  endfunction

  // Check all outputs against the model for the current cycle, then advance one clock.
  task automatic tick();
    logic                     exp_we;
    logic                     exp_rdy;
    logic [DATA_W:0]          f1;
    logic [DATA_W:0]          f2;
    logic [ADDR_W+DATA_W-1:0] e;
    #1;
    exp_we  = !rst && drain_en && (q.size() != 0);
    exp_rdy = !rst && (q.size() != DEPTH);
    f1 = rst ? '0 : model_fwd(look_sel1);
    f2 = rst ? '0 : model_fwd(look_sel2);
    chk("rf_we",    32'(rf_we),    32'(exp_we));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("count",    32'(count),    rst ? 32'd0 : 32'(q.size()));
    chk("hit1", 32'(hit1), 32'(f1[DATA_W]));
    chk("fwd1", 32'(fwd1), 32'(f1[DATA_W-1:0]));
    chk("hit2", 32'(hit2), 32'(f2[DATA_W]));
    chk("fwd2", 32'(fwd2), 32'(f2[DATA_W-1:0]));
    if (exp_we) begin
      e = q.pop_front();
      chk("rf_sel",  32'(rf_sel),  32'(e[ADDR_W+DATA_W-1:DATA_W]));
      chk("rf_data", 32'(rf_data), 32'(e[DATA_W-1:0]));
    end else begin
      chk("rf_sel_idle",  32'(rf_sel),  32'd0);
      chk("rf_data_idle", 32'(rf_data), 32'd0);
    end
    if (exp_rdy && in_valid && (in_sel != '0)) q.push_back({in_sel, in_data});
    @(posedge clk);
    if (rst) q.delete();
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] s, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0;
    drain_en = 1'b0; look_sel1 = '0; look_sel2 = '0;
    @(posedge clk); #1;
    tick();
    tick();
    rst = 1'b0;

    // Single write with drain enabled.
    drain_en = 1'b1;
    push(4'd3, 16'h1234);
    look_sel1 = 4'd3;
    #1;
    chk("t1_we", 32'(rf_we), 32'd1);
    chk("t1_hit", 32'(hit1), 32'd1);
    tick();
    tick();

    // Fill to full with drain held off; fifth offer refused.
    drain_en = 1'b0;
    look_sel1 = 4'd2; look_sel2 = 4'd4;
    for (int i = 1; i <= 4; i++) push(ADDR_W'(i), 16'hA000 + 16'(i));
    push(4'd9, 16'hBEEF);
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    // No pass-through while full, even with a drain in the same cycle.
    drain_en = 1'b1;
    push(4'd6, 16'h6666);
    for (int i = 0; i < 4; i++) tick();

    // Two writes to the same register: youngest forwarded.
    drain_en = 1'b0;
    look_sel1 = 4'd5; look_sel2 = 4'd0;
    push(4'd5, 16'h0011);
    push(4'd5, 16'h0022);
    #1;
    chk("fwd_young", 32'(fwd1), 32'h0022);
    drain_en = 1'b1;
    tick();
    chk("fwd_after1", 32'(fwd1), 32'h0022);
    tick();
    chk("hit_after2", 32'(hit1), 32'd0);
    chk("fwd_after2", 32'(fwd1), 32'd0);
    tick();

    // Register 0 write handshakes but is dropped.
    look_sel1 = 4'd0;
    in_valid = 1'b1; in_sel = 4'd0; in_data = 16'hFFFF;
    #1;
    chk("r0_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("r0_count", 32'(count), 32'd0);
    tick();

    // Continuous push plus drain across pointer wraps.
    drain_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      look_sel1 = ADDR_W'($urandom_range(1, 15));
      look_sel2 = in_sel;
      in_valid = 1'b1;
      in_sel   = ADDR_W'($urandom_range(1, 15));
      in_data  = DATA_W'($urandom);
      tick();
      if (i > 0) chk("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Reset with entries pending: nothing stale drains afterwards.
    drain_en = 1'b0;
    look_sel1 = 4'd7; look_sel2 = 4'd8;
    push(4'd7, 16'h0707);
    push(4'd8, 16'h0808);
    push(4'd9, 16'h0909);
    drain_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_hit1", 32'(hit1), 32'd0);
    chk("rst_hit2", 32'(hit2), 32'd0);
    for (int i = 0; i < 3; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Buffered writer for the 16×16 register file's single write port. Execution units hand results to it over a valid/ready handshake. It holds up to DEPTH pending writes in a FIFO and drains one per cycle onto the register file write port (`we`, `sel_in`, `in`) whenever draining is enabled. It also gives the read-operand path forwarding lookups so that values still queued are visible before they land in the register file.

## Interface
- DEPTH, 4: number of queued writes; power of two, at least 2.
- DATA_W, 16: register width.
- ADDR_W, 4: register select width.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: producer offers a write.
- `in_ready` out 1: queue can accept.
- `in_sel` in ADDR_W: destination register.
- `in_data` in DATA_W: value to write.
- `drain_en` in 1: write port available this cycle; 0 when another agent owns the port.
- `rf_we` out 1: drives the register file `we`.
- `rf_sel` out ADDR_W: drives the register file `sel_in`.
- `rf_data` out DATA_W: drives the register file `in`.
- `look_sel1`, `look_sel2` in ADDR_W: operand selects from the read path.
- `hit1`, `hit2` out 1: a queued write targets the corresponding select.
- `fwd1`, `fwd2` out DATA_W: youngest queued value for that select; 0 when no hit.
- `count` out $clog2(DEPTH)+1: number of queued entries.

## Operation
- FIFO state: `head` and `tail` pointers of width $clog2(DEPTH), wrapping modulo DEPTH. `count` ranges 0..DEPTH.
- Accept condition: `in_valid && in_ready` at a rising edge.
  - `in_sel != 0`: the entry {sel, data} is written at `tail`, then `tail` advances.
  - `in_sel == 0`: the handshake completes but nothing is enqueued. Register 0 is never written.
- `in_ready = !rst && (count != DEPTH)`.
  - No pass-through when full: while full, `in_ready` stays 0 even if a drain occurs in the same cycle.
- Drain:
  - Combinationally, `rf_we = drain_en && (count != 0)`, with `rf_sel` and `rf_data` taken from the `head` entry.
  - When `rf_we` is 0, `rf_sel` and `rf_data` are 0.
  - At the edge where `rf_we` is 1, `head` advances. The register file captures the value on the same edge.
- Accept and drain in the same cycle: `count` is unchanged and both pointers advance.
- Ordering: writes reach the register file strictly in acceptance order. Repeated writes to the same register are all performed, oldest first.
- Forwarding, evaluated combinationally over valid entries only:
  - `hitN` = 1 if any entry has `sel == look_selN` and `look_selN != 0`.
  - `fwdN` is the data of the youngest such entry, i.e. the one nearest `tail`.
  - The entry currently presented on `rf_*` still counts as queued. It is valid until the edge that pops it.
  - The current-cycle `in_data` is not forwarded.
- Reset:
  - All entries are discarded, `head`, `tail` and `count` are set to 0, and all outputs go to 0.
  - Reset mid-drain: writes not yet popped are lost, and no `rf_we` is asserted during the reset cycle.

## Timing
- Latency: an entry accepted at edge N is presented on `rf_*` in cycle N+1. It is written at edge N+1 if `drain_en` is 1 and no older entries remain.
- Throughput: one accept per cycle, and one drain per cycle.
- All outputs are combinational from state plus `drain_en` and `look_sel*`. There are no combinational paths from `in_valid`, `in_sel` or `in_data` to any output.
- Reset values: `in_ready` 0 during `rst`, then 1 in the first cycle after. `rf_we`, `rf_sel`, `rf_data`, `hit1`, `hit2`, `fwd1`, `fwd2` and `count` are all 0.
- Boundary cases:
  - Empty with `drain_en` = 1: `rf_we` is 0.
  - Full with `drain_en` = 0: `in_ready` is 0 and the state holds indefinitely.
  - Pointer wrap from DEPTH-1 to 0 must preserve order and keep forwarding correct.

## Test plan
- Reset, then push (sel 3, 0x1234) with `drain_en` = 1 → in the next cycle `rf_we` = 1, `rf_sel` = 3, `rf_data` = 0x1234, `hit1` = 1 for `look_sel1` = 3. In the following cycle `count` = 0 and `rf_we` = 0.
- Hold `drain_en` = 0 and push sel 1..4 with data 0xA001..0xA004 → `count` = 4 and `in_ready` = 0. A fifth `in_valid` is not accepted. Then set `drain_en` = 1 → four consecutive writes appear in order 1, 2, 3, 4.
- With `drain_en` = 0, push (5, 0x0011) then (5, 0x0022) → `hit1` = 1 and `fwd1` = 0x0022. After one drain, `fwd1` is still 0x0022. After two drains, `hit1` = 0 and `fwd1` = 0.
- Push (0, 0xFFFF) → `in_ready` is 1 and the handshake completes, but `count` stays 0, `rf_we` never asserts, and `hit1` = 0 for `look_sel1` = 0.
- Run 20 cycles of continuous push plus drain with random sel 1..15 → `count` stays at 1 after the first cycle, and the write sequence on `rf_*` matches the push sequence exactly across pointer wraps.
- Fill 3 entries with `drain_en` = 0, then assert `rst` for 1 cycle → `count` = 0, `rf_we` = 0, and `hit*` = 0. With `drain_en` = 1 afterwards, no stale writes appear.
